// File: rtl/ext_share_arbiter_pkg.sv
// Shared constants for the extension-sharing arbiter: extension mode encodings and
// performance counter width.
package ext_share_arbiter_pkg;

    localparam logic [1:0] EXT_MODE_SEXT = 2'b00;
    localparam logic [1:0] EXT_MODE_ZEXT = 2'b01;
    localparam logic [1:0] EXT_MODE_LUI  = 2'b10;
    localparam logic [1:0] EXT_MODE_BOFF = 2'b11;

    localparam int EXT_PERF_W = 32;

    typedef logic [31:0] ext_word_t;

endpackage

// File: rtl/ext_share_arbiter_if.sv
// Request/response bundle between the cores and the shared extension unit.
// slave = the arbiter, master = the core side.
interface ext_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);

    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [16*NUM_REQ-1:0] req_data_i;
    logic [2*NUM_REQ-1:0]  req_mode_i;
    logic [NUM_REQ-1:0]    resp_valid_o;
    logic [31:0]           resp_data_o;
    logic [ID_W-1:0]       resp_id_o;
    logic [NUM_REQ-1:0]    resp_ready_i;

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  req_mode_i,
        input  resp_ready_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_data_o,
        output resp_id_o
    );

    modport master (
        output req_valid_i,
        output req_data_i,
        output req_mode_i,
        output resp_ready_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_data_o,
        input  resp_id_o
    );

endinterface

// File: rtl/ext_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner, one per enabled cycle.
// Owns the pointer; reset points at the last core so core 0 wins first.
module ext_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_valid
);

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] pick;
    logic               found;
    int                 cand;

    always_comb begin
        pick      = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i + 1;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && cand == j && req[j]) begin
                    found     = 1'b1;
                    pick[j]   = 1'b1;
                    grant_idx = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant       = enable ? pick : '0;
        grant_valid = enable && found;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= ID_W'(NUM_REQ - 1);
        end else if (grant_valid) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/ext_share_arbiter.sv
// One immediate-extension datapath shared by NUM_REQ cores behind a round-robin arbiter and a
// single tagged response stage. Define EXT_SHARE_PERF_EN to add per-core grant/stall counters.
module ext_share_arbiter
    import ext_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef EXT_SHARE_PERF_EN
    output logic [EXT_PERF_W*NUM_REQ-1:0] perf_grant_o,
    output logic [EXT_PERF_W-1:0]         perf_stall_o,
`endif
    ext_share_arbiter_if.slave            bus
);

    logic               stage_valid_q;
    ext_word_t          stage_data_q;
    logic [ID_W-1:0]    stage_id_q;

    logic [NUM_REQ-1:0] resp_valid;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic               free;
    logic               enable;
    logic [15:0]        sel_data;
    logic [1:0]         sel_mode;
    ext_word_t          ext_result;

    always_comb begin
        resp_valid = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            resp_valid[j] = stage_valid_q && (stage_id_q == ID_W'(j));
        end
    end

    // Only the owner's ready can drain the stage; others are masked by resp_valid.
    always_comb begin
        free   = !stage_valid_q || (|(bus.resp_ready_i & resp_valid));
        enable = free && !rst_i;
    end

    ext_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req         (bus.req_valid_i),
        .enable      (enable),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_data = '0;
        sel_mode = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == ID_W'(j)) begin
                sel_data = bus.req_data_i[16*j +: 16];
                sel_mode = bus.req_mode_i[2*j +: 2];
            end
        end
    end

    always_comb begin
        ext_result = '0;
        case (sel_mode)
            EXT_MODE_SEXT: ext_result = {{16{sel_data[15]}}, sel_data};
            EXT_MODE_ZEXT: ext_result = {16'h0000, sel_data};
            EXT_MODE_LUI:  ext_result = {sel_data, 16'h0000};
            EXT_MODE_BOFF: ext_result = {{14{sel_data[15]}}, sel_data, 2'b00};
            default:       ext_result = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            stage_id_q    <= '0;
        end else if (grant_valid) begin
            stage_valid_q <= 1'b1;
            stage_data_q  <= ext_result;
            stage_id_q    <= grant_idx;
        end else if (free) begin
            stage_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready_o  = grant;
    assign bus.resp_valid_o = resp_valid;
    assign bus.resp_data_o  = stage_data_q;
    assign bus.resp_id_o    = stage_id_q;

`ifdef EXT_SHARE_PERF_EN
    logic [EXT_PERF_W-1:0] grant_cnt_q [NUM_REQ];
    logic [EXT_PERF_W-1:0] stall_cnt_q;
    logic                  stall;

    assign stall = (|bus.req_valid_i) && !free;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                grant_cnt_q[j] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant[j] && grant_cnt_q[j] != '1) begin
                    grant_cnt_q[j] <= grant_cnt_q[j] + EXT_PERF_W'(1);
                end
            end
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + EXT_PERF_W'(1);
            end
        end
    end

    always_comb begin
        perf_grant_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            perf_grant_o[EXT_PERF_W*j +: EXT_PERF_W] = grant_cnt_q[j];
        end
    end

    assign perf_stall_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ext_share_arbiter.sv
// Scoreboard bench for ext_share_arbiter: directed reset/mode/fairness/backpressure phases, then
// randomized traffic, checked against a round-robin reference model.
module tb_ext_share_arbiter;
    import ext_share_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int IW = 1;
    localparam int DW = 16 * NR;
    localparam int MW = 2 * NR;
    localparam logic [DW-1:0] DM = DW'(16'hFFFF);
    localparam logic [MW-1:0] MM = MW'(2'b11);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    ext_share_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

`ifdef EXT_SHARE_PERF_EN
    logic [32*NR-1:0] perf_grant;
    logic [31:0]      perf_stall;
`endif

    ext_share_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (IW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
`ifdef EXT_SHARE_PERF_EN
        .perf_grant_o (perf_grant),
        .perf_stall_o (perf_stall),
`endif
        .bus          (bus)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit bit_of(input logic [31:0] vec, input int i);
        return 1'(vec >> i);
    endfunction

    // Reference extension: plain signed/unsigned arithmetic on the immediate.
    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        int s;
        s = int'($signed(d));
        case (m)
            EXT_MODE_SEXT: return 32'(s);
            EXT_MODE_ZEXT: return 32'(d);
            EXT_MODE_LUI:  return 32'(d) << 16;
            default:       return 32'(s * 4);
        endcase
    endfunction

    // Reference model: last winner, stage occupancy, perf tallies.
    int          m_last = NR - 1;
    bit          m_valid = 1'b0;
    int          m_owner = 0;
    int          m_grants[NR];
    int          m_stall = 0;
    bit          m_free;
    int          m_g;
    int          m_c;
    logic [NR-1:0] m_rdy;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            check("req_ready_in_reset", 64'(bus.req_ready_o), 64'(0));
            sb_q.delete();
            m_valid = 1'b0;
            m_last  = NR - 1;
            m_stall = 0;
            for (int i = 0; i < NR; i++) m_grants[i] = 0;
        end else begin
            m_free = !m_valid || bit_of(32'(bus.resp_ready_i), m_owner);
            m_g = -1;
            if (m_free) begin
                for (int k = 1; k <= NR; k++) begin
                    m_c = (m_last + k) % NR;
                    if (m_g < 0 && bit_of(32'(bus.req_valid_i), m_c)) m_g = m_c;
                end
            end
            m_rdy = (m_g >= 0) ? (NR'(1) << m_g) : '0;
            check("req_ready", 64'(bus.req_ready_o), 64'(m_rdy));
            if (bus.req_valid_i != '0 && !m_free) m_stall++;
            if (m_g >= 0) begin
                sb_q.push_back('{m_g,
                                 ref_ext(16'(bus.req_data_i >> (16 * m_g)),
                                         2'(bus.req_mode_i >> (2 * m_g))),
                                 cyc});
                m_last  = m_g;
                m_valid = 1'b1;
                m_owner = m_g;
                m_grants[m_g]++;
            end else if (m_free) begin
                m_valid = 1'b0;
            end
        end
    end

    // Monitor: the queue front is what the stage must present once its acceptance edge has passed.
    exp_t mon_e;
    always @(negedge clk) begin
        #3;
        if (rst) begin
            if (rst_q) begin
                check("resp_valid_in_reset", 64'(bus.resp_valid_o), 64'(0));
                check("resp_data_in_reset", 64'(bus.resp_data_o), 64'(0));
                check("resp_id_in_reset", 64'(bus.resp_id_o), 64'(0));
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            mon_e = sb_q[0];
            check("resp_valid", 64'(bus.resp_valid_o), 64'(NR'(1) << mon_e.id));
            check("resp_data", 64'(bus.resp_data_o), 64'(mon_e.data));
            check("resp_id", 64'(bus.resp_id_o), 64'(mon_e.id));
            if (bit_of(32'(bus.resp_ready_i), mon_e.id)) void'(sb_q.pop_front());
        end else begin
            check("resp_idle", 64'(bus.resp_valid_o), 64'(0));
        end
    end

    logic [NR-1:0] acc = '0;

    task automatic drive(input logic r, input logic [NR-1:0] v, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, input logic [NR-1:0] rr);
        @(negedge clk);
        rst              = r;
        bus.req_valid_i  = v;
        bus.req_data_i   = d;
        bus.req_mode_i   = m;
        bus.resp_ready_i = rr;
        #4;
        acc = bus.req_valid_i & bus.req_ready_o;
    endtask

    logic [NR-1:0] rv;
    logic [DW-1:0] rd;
    logic [MW-1:0] rm;
    logic [NR-1:0] rrr;

    initial begin
        bus.req_valid_i  = '0;
        bus.req_data_i   = '0;
        bus.req_mode_i   = '0;
        bus.resp_ready_i = '0;

        // Reset with every core requesting, then fairness under full throughput.
        repeat (2) drive(1'b1, 2'b11, {16'h1234, 16'h8001}, {EXT_MODE_LUI, EXT_MODE_SEXT}, 2'b11);
        repeat (8) drive(1'b0, 2'b11, {16'h1234, 16'h8001}, {EXT_MODE_LUI, EXT_MODE_SEXT}, 2'b11);

        // Every mode from core 0 with d = 0x8001.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b01, {16'h0000, 16'h8001}, MW'(i), 2'b11);
        end
        drive(1'b0, 2'b00, '0, '0, 2'b11);

        // Core 1 result held back while core 0 waits; core 0's ready must not drain it.
        drive(1'b0, 2'b10, {16'hC3A5, 16'h0000}, {EXT_MODE_BOFF, EXT_MODE_SEXT}, 2'b00);
        repeat (5) drive(1'b0, 2'b01, {16'h0000, 16'h7FFE}, {EXT_MODE_SEXT, EXT_MODE_ZEXT}, 2'b01);
        drive(1'b0, 2'b01, {16'h0000, 16'h7FFE}, {EXT_MODE_SEXT, EXT_MODE_ZEXT}, 2'b11);
        drive(1'b0, 2'b00, '0, '0, 2'b11);

        // Random traffic; a pending request keeps its data until accepted or withdrawn.
        rv = '0;
        rd = '0;
        rm = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (bit_of(32'(rv), i) && !bit_of(32'(acc), i)) begin
                    if ($urandom_range(0, 4) == 0) rv &= ~(NR'(1) << i);
                end else begin
                    if ($urandom_range(0, 9) < 6) rv |= NR'(1) << i;
                    else rv &= ~(NR'(1) << i);
                    rd = (rd & ~(DM << (16 * i))) | ((DW'($urandom) & DM) << (16 * i));
                    rm = (rm & ~(MM << (2 * i))) | ((MW'($urandom) & MM) << (2 * i));
                end
            end
            rrr = NR'($urandom);
            if ($urandom_range(0, 3) != 0) rrr = '1;
            drive(($urandom_range(0, 99) == 0), rv, rd, rm, rrr);
        end

        repeat (3) drive(1'b0, '0, '0, '0, '1);

`ifdef EXT_SHARE_PERF_EN
        for (int i = 0; i < NR; i++) begin
            check("perf_grant", 64'(32'(perf_grant >> (32 * i))), 64'(m_grants[i]));
        end
        check("perf_stall", 64'(perf_stall), 64'(m_stall));
        drive(1'b1, '0, '0, '0, '1);
        drive(1'b0, '0, '0, '0, '1);
        check("perf_grant_cleared", 64'(perf_grant), 64'(m_grants[0] + m_grants[1]));
        check("perf_stall_cleared", 64'(perf_stall), 64'(m_stall));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ext_share_arbiter.md
Name: ext_share_arbiter

Overview:
- Shares one immediate-extension datapath between NUM_REQ requesting cores in the multi-core CPU.
- Each core presents a 16-bit immediate plus an extension mode.
- A round-robin arbiter grants one request per cycle and computes the 32-bit result.
- The result is held in a single registered response stage, tagged with the owner core, until that core accepts it.

Parameters:
- NUM_REQ, 2: number of requesting cores (2..4).
- ID_W, 1: width of the owner tag; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  NUM_REQ  per-core request valid.
- req_ready_o  output  NUM_REQ  per-core request accepted this cycle.
- req_data_i  input  16*NUM_REQ  immediates; core n occupies [16n+15:16n].
- req_mode_i  input  2*NUM_REQ  extension mode per core; core n occupies [2n+1:2n].
- resp_valid_o  output  NUM_REQ  result valid for core n.
- resp_data_o  output  32  result of the response stage; shared bus, qualified by resp_valid_o.
- resp_id_o  output  ID_W  owner tag of the response stage.
- resp_ready_i  input  NUM_REQ  core n consumes its result.

Behaviour:
- Synchronous reset, active high:
  - All outputs are 0: req_ready_o, resp_valid_o, resp_data_o, resp_id_o.
  - Round-robin pointer is set so core 0 has the highest priority on the first cycle after reset.
- Reset mid-operation discards any held response; a pending request is not accepted in the reset cycle.
- Modes, with d = the 16-bit immediate:
  - 00 SEXT: {16{d[15]}, d}.
  - 01 ZEXT: {16'h0, d}.
  - 10 LUI: {d, 16'h0}.
  - 11 BOFF: {{14{d[15]}}, d, 2'b00}, i.e. the sign-extended value shifted left by 2.
- Stage free condition: free = !stage_valid || resp_ready_i[stage_id].
  - Draining and refilling in the same cycle gives full throughput of 1 result per cycle.
- Arbitration, evaluated combinationally each cycle when free:
  - Grant the first core with req_valid_i set, searching from pointer+1 upward modulo NUM_REQ.
  - req_ready_o is one-hot on the granted core; it is all-zero when not free or when nothing is requested.
- Handshake:
  - A request transfers when req_valid_i[n] && req_ready_o[n].
  - Cores must hold data and mode stable while valid and not ready.
  - A core may drop valid without being granted; no ordering is implied.
- Transfer cycle, at the clock edge:
  - stage_valid <= 1, resp_data_o <= extended result, resp_id_o <= n.
  - Pointer <= n.
- Latency is exactly one cycle: resp_valid_o[n] rises in the cycle after acceptance.
- resp_valid_o[n] = stage_valid && (resp_id_o == n).
  - resp_ready_i of non-owner cores is ignored.
- Drain without refill: stage_valid <= 0; resp_data_o and resp_id_o hold their last values.
- Backpressure: while the owner holds resp_ready_i low:
  - The stage holds.
  - All req_ready_o are 0, so no request is lost or overwritten.
- Simultaneous events:
  - All cores valid → strict rotation 0,1,…,NUM_REQ-1,0.
  - A single valid core is granted every free cycle regardless of the pointer.
- Core indices at or above NUM_REQ never exist; tag values at or above NUM_REQ are never produced.

Optional Feature:
- Macro: EXT_SHARE_PERF_EN.
- Defined:
  - Adds output perf_grant_o, 32*NUM_REQ, one counter per core.
  - Each counter increments on every accepted transfer of its core.
  - Counters saturate at 32'hFFFF_FFFF and are cleared by rst_i.
  - Adds output perf_stall_o, 32 bits: counts cycles where any req_valid_i is set while not free, with the same saturation and reset.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Decomposition:
- Shared header ext_share_defs.vh:
  - Mode constants EXT_MODE_SEXT/ZEXT/LUI/BOFF (2'b00..2'b11).
  - Counter width EXT_PERF_W = 32.
- One sub-module, ext_rr_arbiter:
  - Parameter NUM_REQ; inputs req vector, enable (= free), clk_i, rst_i.
  - Outputs one-hot grant and encoded grant index.
  - Owns the pointer register.
- The extension mux stays inline in ext_share_arbiter.

Test Plan:
- Reset: assert rst_i for 2 cycles with all cores valid → req_ready_o=0, resp_valid_o=0 during reset; the first grant after release goes to core 0.
- Modes: core 0 sends d=16'h8001 in each mode → results 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, each one cycle after acceptance with resp_id_o=0.
- Fairness: both cores valid continuously, all resp_ready_i=1 → grants alternate 0,1,0,1 with one result per cycle; 8 cycles give 4 grants each.
- Backpressure: core 1 result pending with resp_ready_i[1]=0 for 5 cycles while core 0 is valid → req_ready_o=0 throughout and resp_data_o stable; after ready rises, core 0 is granted in the same cycle.
- Non-owner ready: resp_ready_i[0]=1 while the stage belongs to core 1 → the stage does not drain.
- Perf (EXT_SHARE_PERF_EN): 3 grants to core 0 and 2 stall cycles → perf_grant_o[31:0]=3, perf_stall_o=2; the counters are cleared by reset.
